// File: rtl/pw_fault_supervisor_if.sv
// ---------------------------------------------------------------------------
// pw_fault_supervisor_if
//   Control/status bundle between the pulse-width fault supervisor and its
//   surroundings: the width-checker result strobes, the system control inputs
//   and the status outputs.
//   master : drives enable / res_valid / res_ok / fault_clr, observes status
//   slave  : the supervisor; consumes the inputs, drives chk_rst / running /
//            fault / fault_cause / pass_cnt / fail_cnt
// ---------------------------------------------------------------------------
interface pw_fault_supervisor_if #(
   parameter int CNT_BITS = 16
);
   logic                enable;
   logic                res_valid;
   logic                res_ok;
   logic                fault_clr;
   logic                chk_rst;
   logic                running;
   logic                fault;
   logic [1:0]          fault_cause;
   logic [CNT_BITS-1:0] pass_cnt;
   logic [CNT_BITS-1:0] fail_cnt;

   modport master (
      output enable, res_valid, res_ok, fault_clr,
      input  chk_rst, running, fault, fault_cause, pass_cnt, fail_cnt
   );

   modport slave (
      input  enable, res_valid, res_ok, fault_clr,
      output chk_rst, running, fault, fault_cause, pass_cnt, fail_cnt
   );
endinterface

// File: rtl/pw_fault_supervisor.sv
// ---------------------------------------------------------------------------
// pw_fault_supervisor
//   Sequences a pulse-width checking engine (holds it in reset, arms it for
//   ARM_CYCLES cycles, then lets it run) and supervises its per-pulse result
//   strobes. A fault is latched after FAIL_LIMIT consecutive violations or
//   after TIMEOUT cycles in RUN without any result.
// Ports
//   i_clk   : system clock
//   i_rst   : synchronous active-high reset
//   bus     : slave side of pw_fault_supervisor_if
//             in : enable, res_valid, res_ok, fault_clr
//             out: chk_rst, running, fault, fault_cause[1:0],
//                  pass_cnt[CNT_BITS-1:0], fail_cnt[CNT_BITS-1:0]
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module pw_fault_supervisor #(
   parameter int FAIL_LIMIT = 3,
   parameter int TIMEOUT    = 1000,
   parameter int ARM_CYCLES = 4,
   parameter int CNT_BITS   = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   pw_fault_supervisor_if.slave  bus
);
   localparam int CW = $clog2(FAIL_LIMIT + 1);
   localparam int WW = $clog2(TIMEOUT);
   localparam int AW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

   localparam logic [CW-1:0]       CONSEC_MAX = CW'(FAIL_LIMIT);
   localparam logic [CW-1:0]       CONSEC_TRIP = CW'(FAIL_LIMIT - 1);
   localparam logic [WW-1:0]       WD_LAST = WW'(TIMEOUT - 1);
   localparam logic [AW-1:0]       ARM_LAST = AW'(ARM_CYCLES - 1);
   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

   localparam logic [1:0] CAUSE_NONE   = 2'b00;
   localparam logic [1:0] CAUSE_CONSEC = 2'b01;
   localparam logic [1:0] CAUSE_TMO    = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_FAULT} state_t;

   state_t              r_state, w_state_nxt;
   logic [1:0]          r_cause, w_cause_nxt;
   logic                r_chk_rst, r_running, r_fault;
   logic [CNT_BITS-1:0] r_pass, r_fail;
   logic [CW-1:0]       r_consec;
   logic [WW-1:0]       r_wd;
   logic [AW-1:0]       r_arm;

   logic w_enter_arm, w_arm_inc, w_pass_inc, w_fail_inc, w_wd_clr, w_wd_inc;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state and datapath controls
   always_comb begin
      w_state_nxt = r_state;
      w_cause_nxt = r_cause;
      w_enter_arm = 1'b0;
      w_arm_inc   = 1'b0;
      w_pass_inc  = 1'b0;
      w_fail_inc  = 1'b0;
      w_wd_clr    = 1'b0;
      w_wd_inc    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.enable) begin
               w_state_nxt = S_ARM;
               w_enter_arm = 1'b1;
            end
         end
         S_ARM: begin
            if (!bus.enable)          w_state_nxt = S_IDLE;
            else if (r_arm == ARM_LAST) w_state_nxt = S_RUN;
            else                       w_arm_inc = 1'b1;
         end
         S_RUN: begin
            // Dropping enable wins over a coincident result strobe.
            if (!bus.enable) begin
               w_state_nxt = S_IDLE;
            end else if (bus.res_valid) begin
               // A result in the terminal watchdog cycle still rescues it.
               w_wd_clr = 1'b1;
               if (bus.res_ok) begin
                  w_pass_inc = 1'b1;
               end else begin
                  w_fail_inc = 1'b1;
                  if (r_consec >= CONSEC_TRIP) begin
                     w_state_nxt = S_FAULT;
                     w_cause_nxt = CAUSE_CONSEC;
                  end
               end
            end else if (r_wd == WD_LAST) begin
               w_state_nxt = S_FAULT;
               w_cause_nxt = CAUSE_TMO;
            end else begin
               w_wd_inc = 1'b1;
            end
         end
         S_FAULT: begin
            // Only fault_clr leaves FAULT; enable merely picks the target.
            if (bus.fault_clr) begin
               w_cause_nxt = CAUSE_NONE;
               if (bus.enable) begin
                  w_state_nxt = S_ARM;
                  w_enter_arm = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Registered outputs, decoded from the next state so they line up with it
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_chk_rst <= 1'b1;
         r_running <= 1'b0;
         r_fault   <= 1'b0;
         r_cause   <= CAUSE_NONE;
      end else begin
         r_chk_rst <= (w_state_nxt != S_RUN);
         r_running <= (w_state_nxt == S_RUN);
         r_fault   <= (w_state_nxt == S_FAULT);
         r_cause   <= w_cause_nxt;
      end
   end

   // Statistics, consecutive-fail counter, watchdog and arm timer
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pass   <= '0;
         r_fail   <= '0;
         r_consec <= '0;
         r_wd     <= '0;
         r_arm    <= '0;
      end else if (w_enter_arm) begin
         r_pass   <= '0;
         r_fail   <= '0;
         r_consec <= '0;
         r_wd     <= '0;
         r_arm    <= '0;
      end else begin
         if (w_arm_inc) r_arm <= r_arm + 1'b1;
         if (w_pass_inc) begin
            if (r_pass != CNT_MAX) r_pass <= r_pass + 1'b1;
            r_consec <= '0;
         end
         if (w_fail_inc) begin
            if (r_fail != CNT_MAX)      r_fail   <= r_fail + 1'b1;
            if (r_consec != CONSEC_MAX) r_consec <= r_consec + 1'b1;
         end
         if (w_wd_clr)      r_wd <= '0;
         else if (w_wd_inc) r_wd <= r_wd + 1'b1;
      end
   end

   assign bus.chk_rst     = r_chk_rst;
   assign bus.running     = r_running;
   assign bus.fault       = r_fault;
   assign bus.fault_cause = r_cause;
   assign bus.pass_cnt    = r_pass;
   assign bus.fail_cnt    = r_fail;

endmodule

// File: tb/tb_pw_fault_supervisor.sv
module tb_pw_fault_supervisor;
   localparam int CNT_BITS = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   pw_fault_supervisor_if #(.CNT_BITS(CNT_BITS)) bus ();

   pw_fault_supervisor #(
      .FAIL_LIMIT(3), .TIMEOUT(1000), .ARM_CYCLES(4), .CNT_BITS(CNT_BITS)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic ok);
      bus.res_valid = 1'b1;
      bus.res_ok    = ok;
      tick();
      bus.res_valid = 1'b0;
      bus.res_ok    = 1'b0;
   endtask

   // From IDLE: raise enable, expect RUN after exactly 5 edges.
   task automatic arm_to_run();
      int n;
      bus.enable = 1'b1;
      n = 0;
      while (bus.running !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      n_total++;
      if (n !== 5) $display("FAIL arm_to_run edges=%0d expected 5", n);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      n_total++;
      if ({bus.chk_rst, bus.running, bus.fault, bus.fault_cause} !== 5'b10000)
         $display("FAIL reset_flags got %b expected 10000",
                  {bus.chk_rst, bus.running, bus.fault, bus.fault_cause});
      else n_pass++;
      n_total++;
      if (bus.pass_cnt !== 16'd0 || bus.fail_cnt !== 16'd0)
         $display("FAIL reset_cnt pass=%0d fail=%0d expected 0/0", bus.pass_cnt, bus.fail_cnt);
      else n_pass++;
      rst = 1'b0;
      tick();
      n_total++;
      if (bus.chk_rst !== 1'b1 || bus.running !== 1'b0)
         $display("FAIL idle_hold chk_rst=%b running=%b expected 1/0", bus.chk_rst, bus.running);
      else n_pass++;
   endtask

   task automatic test_arm();
      int bad;
      bad = 0;
      bus.enable = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (bus.chk_rst !== 1'b1 || bus.running !== 1'b0) bad++;
      end
      n_total++;
      if (bad != 0) $display("FAIL arm_window bad_cycles=%0d expected 0", bad);
      else n_pass++;
      tick();
      n_total++;
      if (bus.chk_rst !== 1'b0 || bus.running !== 1'b1)
         $display("FAIL run_entry chk_rst=%b running=%b expected 0/1", bus.chk_rst, bus.running);
      else n_pass++;
   endtask

   task automatic test_pass();
      strobe(1'b1);
      n_total++;
      if (bus.pass_cnt !== 16'd1) $display("FAIL pass_latency pass_cnt=%0d expected 1", bus.pass_cnt);
      else n_pass++;
      for (int i = 0; i < 4; i++) strobe(1'b1);
      n_total++;
      if (bus.pass_cnt !== 16'd5 || bus.fail_cnt !== 16'd0 || bus.fault !== 1'b0)
         $display("FAIL pass_five pass=%0d fail=%0d fault=%b expected 5/0/0",
                  bus.pass_cnt, bus.fail_cnt, bus.fault);
      else n_pass++;
   endtask

   task automatic test_consec();
      strobe(1'b0); strobe(1'b0); strobe(1'b1); strobe(1'b0); strobe(1'b0);
      n_total++;
      if (bus.fault !== 1'b0 || bus.fail_cnt !== 16'd4 || bus.pass_cnt !== 16'd6)
         $display("FAIL consec_pre fault=%b fail=%0d pass=%0d expected 0/4/6",
                  bus.fault, bus.fail_cnt, bus.pass_cnt);
      else n_pass++;
      strobe(1'b0);
      n_total++;
      if (bus.fault !== 1'b1 || bus.fault_cause !== 2'b01 || bus.fail_cnt !== 16'd5)
         $display("FAIL consec_trip fault=%b cause=%b fail=%0d expected 1/01/5",
                  bus.fault, bus.fault_cause, bus.fail_cnt);
      else n_pass++;
      n_total++;
      if (bus.running !== 1'b0 || bus.chk_rst !== 1'b1)
         $display("FAIL fault_outs running=%b chk_rst=%b expected 0/1", bus.running, bus.chk_rst);
      else n_pass++;
      strobe(1'b0); strobe(1'b1); strobe(1'b0);
      n_total++;
      if (bus.fail_cnt !== 16'd5 || bus.pass_cnt !== 16'd6 || bus.fault_cause !== 2'b01)
         $display("FAIL fault_frozen fail=%0d pass=%0d cause=%b expected 5/6/01",
                  bus.fail_cnt, bus.pass_cnt, bus.fault_cause);
      else n_pass++;
   endtask

   task automatic test_clear_rearm();
      int bad;
      bus.fault_clr = 1'b1;
      tick();
      bus.fault_clr = 1'b0;
      n_total++;
      if (bus.fault !== 1'b0 || bus.fault_cause !== 2'b00 || bus.chk_rst !== 1'b1 ||
          bus.pass_cnt !== 16'd0 || bus.fail_cnt !== 16'd0)
         $display("FAIL clear_arm fault=%b cause=%b chk_rst=%b pass=%0d fail=%0d expected 0/00/1/0/0",
                  bus.fault, bus.fault_cause, bus.chk_rst, bus.pass_cnt, bus.fail_cnt);
      else n_pass++;
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (bus.running !== 1'b0 || bus.chk_rst !== 1'b1) bad++;
      end
      tick();
      n_total++;
      if (bad != 0 || bus.running !== 1'b1)
         $display("FAIL rearm_window bad=%0d running=%b expected 0/1", bad, bus.running);
      else n_pass++;
   endtask

   // Entered right after a RUN entry edge.
   task automatic test_timeout();
      int early;
      early = 0;
      for (int i = 0; i < 999; i++) begin
         tick();
         if (bus.fault !== 1'b0) early++;
      end
      tick();
      n_total++;
      if (early != 0 || bus.fault !== 1'b1 || bus.fault_cause !== 2'b10)
         $display("FAIL timeout early=%0d fault=%b cause=%b expected 0/1/10",
                  early, bus.fault, bus.fault_cause);
      else n_pass++;
      bus.fault_clr = 1'b1;
      tick();
      bus.fault_clr = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      early = 0;
      for (int i = 0; i < 999; i++) begin
         tick();
         if (bus.fault !== 1'b0) early++;
      end
      strobe(1'b1);
      n_total++;
      if (early != 0 || bus.fault !== 1'b0 || bus.pass_cnt !== 16'd1 || bus.running !== 1'b1)
         $display("FAIL wd_rescue early=%0d fault=%b pass=%0d running=%b expected 0/0/1/1",
                  early, bus.fault, bus.pass_cnt, bus.running);
      else n_pass++;
      early = 0;
      for (int i = 0; i < 999; i++) begin
         tick();
         if (bus.fault !== 1'b0) early++;
      end
      tick();
      n_total++;
      if (early != 0 || bus.fault !== 1'b1 || bus.fault_cause !== 2'b10)
         $display("FAIL wd_restart early=%0d fault=%b cause=%b expected 0/1/10",
                  early, bus.fault, bus.fault_cause);
      else n_pass++;
   endtask

   task automatic test_clear_idle();
      bus.enable = 1'b0;
      tick(); tick();
      n_total++;
      if (bus.fault !== 1'b1 || bus.fault_cause !== 2'b10)
         $display("FAIL fault_sticky fault=%b cause=%b expected 1/10", bus.fault, bus.fault_cause);
      else n_pass++;
      bus.fault_clr = 1'b1;
      tick();
      bus.fault_clr = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      n_total++;
      if (bus.fault !== 1'b0 || bus.fault_cause !== 2'b00 || bus.running !== 1'b0 || bus.chk_rst !== 1'b1)
         $display("FAIL clear_idle fault=%b cause=%b running=%b chk_rst=%b expected 0/00/0/1",
                  bus.fault, bus.fault_cause, bus.running, bus.chk_rst);
      else n_pass++;
   endtask

   task automatic test_enable_drop();
      arm_to_run();
      strobe(1'b1); strobe(1'b0);
      bus.fault_clr = 1'b1;
      tick();
      bus.fault_clr = 1'b0;
      n_total++;
      if (bus.running !== 1'b1 || bus.fault !== 1'b0)
         $display("FAIL clr_ignored running=%b fault=%b expected 1/0", bus.running, bus.fault);
      else n_pass++;
      bus.enable = 1'b0;
      tick();
      n_total++;
      if (bus.running !== 1'b0 || bus.chk_rst !== 1'b1 || bus.pass_cnt !== 16'd1 || bus.fail_cnt !== 16'd1)
         $display("FAIL enable_drop running=%b chk_rst=%b pass=%0d fail=%0d expected 0/1/1/1",
                  bus.running, bus.chk_rst, bus.pass_cnt, bus.fail_cnt);
      else n_pass++;
      strobe(1'b1); strobe(1'b0);
      n_total++;
      if (bus.pass_cnt !== 16'd1 || bus.fail_cnt !== 16'd1)
         $display("FAIL idle_ignore pass=%0d fail=%0d expected 1/1", bus.pass_cnt, bus.fail_cnt);
      else n_pass++;
   endtask

   task automatic test_rst_fault();
      arm_to_run();
      strobe(1'b0); strobe(1'b0); strobe(1'b0);
      n_total++;
      if (bus.fault !== 1'b1 || bus.fault_cause !== 2'b01)
         $display("FAIL b2b_trip fault=%b cause=%b expected 1/01", bus.fault, bus.fault_cause);
      else n_pass++;
      bus.enable = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_total++;
      if ({bus.chk_rst, bus.running, bus.fault, bus.fault_cause} !== 5'b10000 ||
          bus.pass_cnt !== 16'd0 || bus.fail_cnt !== 16'd0)
         $display("FAIL rst_fault flags=%b pass=%0d fail=%0d expected 10000/0/0",
                  {bus.chk_rst, bus.running, bus.fault, bus.fault_cause}, bus.pass_cnt, bus.fail_cnt);
      else n_pass++;
   endtask

   initial begin
      bus.enable    = 1'b0;
      bus.res_valid = 1'b0;
      bus.res_ok    = 1'b0;
      bus.fault_clr = 1'b0;
      test_reset();
      test_arm();
      test_pass();
      test_consec();
      test_clear_rearm();
      test_timeout();
      test_clear_idle();
      test_enable_drop();
      test_rst_fault();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "time limit");
   end
endmodule
